// File: rtl/ysyx_210247_mem_arbiter_pkg.sv
// Shared encodings for the fetch/data memory arbiter: FSM states, AXI response and size codes.
package ysyx_210247_mem_arbiter_pkg;

  localparam int REG_BUS = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INST = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

endpackage

// File: rtl/ysyx_210247_mem_arbiter.sv
// Muxes fetch and load/store onto one bridge channel; grant 1 cycle after request, one idle cycle between transactions.
// Requesters are held off until the bridge's rw_ready pulse; data wins ties unless fetch has waited MAX_DATA_STREAK grants.
module ysyx_210247_mem_arbiter
  import ysyx_210247_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W          = 64,
  parameter int DATA_W          = 64,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inst_valid,
  output logic                inst_ready,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic [1:0]          inst_size,
  output logic [DATA_W-1:0]   inst_read,
  output logic [1:0]          inst_resp,
  input  logic                data_valid,
  input  logic                data_wen,
  output logic                data_ready,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [1:0]          data_size,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic [DATA_W/8-1:0] data_wstrb,
  output logic [DATA_W-1:0]   data_rdata,
  output logic [1:0]          data_resp,
  output logic                rw_valid,
  input  logic                rw_ready,
  output logic                rw_req,
  output logic [ADDR_W-1:0]   rw_addr,
  output logic [1:0]          rw_size,
  output logic [DATA_W-1:0]   rw_wdata,
  output logic [DATA_W/8-1:0] rw_wstrb,
  input  logic [DATA_W-1:0]   rw_rdata,
  input  logic [1:0]          rw_resp,
  output logic                grant_data,
  output logic                busy
);

  localparam logic [3:0] MAX_STREAK = 4'(MAX_DATA_STREAK);

  arb_state_e          r_state;
  logic [3:0]          r_streak;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_size;
  logic                r_wen;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;

  logic w_pick_data;
  logic w_inst_done;
  logic w_data_done;

  // Data wins unless fetch is also waiting and has already been passed over MAX_DATA_STREAK times.
  assign w_pick_data = data_valid && (!inst_valid || (r_streak < MAX_STREAK));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_streak <= 4'd0;
      r_addr   <= '0;
      r_size   <= 2'b00;
      r_wen    <= 1'b0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_data) begin
            r_state <= ST_DATA;
            r_addr  <= data_addr;
            r_size  <= data_size;
            r_wen   <= data_wen;
            r_wdata <= data_wdata;
            r_wstrb <= data_wstrb;
            if (inst_valid) begin
              r_streak <= (r_streak == MAX_STREAK) ? MAX_STREAK : r_streak + 4'd1;
            end else begin
              r_streak <= 4'd0;
            end
          end else if (inst_valid) begin
            r_state  <= ST_INST;
            r_addr   <= inst_addr;
            r_size   <= inst_size;
            r_wen    <= 1'b0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_streak <= 4'd0;
          end
        end
        ST_INST, ST_DATA: begin
          if (rw_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy       = (r_state != ST_IDLE);
  assign grant_data = (r_state == ST_DATA);
  assign rw_valid   = busy;
  assign rw_req     = grant_data & r_wen;
  assign rw_addr    = r_addr;
  assign rw_size    = r_size;
  assign rw_wdata   = r_wdata;
  assign rw_wstrb   = grant_data ? r_wstrb : '0;

  assign w_inst_done = (r_state == ST_INST) & rw_ready;
  assign w_data_done = (r_state == ST_DATA) & rw_ready;

  assign inst_ready = w_inst_done;
  assign inst_read  = w_inst_done ? rw_rdata : '0;
  assign inst_resp  = w_inst_done ? rw_resp : 2'b00;
  assign data_ready = w_data_done;
  assign data_rdata = w_data_done ? rw_rdata : '0;
  assign data_resp  = w_data_done ? rw_resp : 2'b00;

endmodule

// File: tb/tb_ysyx_210247_mem_arbiter.sv
// Directed bench for the fetch/data arbiter with hand-computed expectations.
module tb_ysyx_210247_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        inst_valid;
  logic        inst_ready;
  logic [63:0] inst_addr;
  logic [1:0]  inst_size;
  logic [63:0] inst_read;
  logic [1:0]  inst_resp;
  logic        data_valid;
  logic        data_wen;
  logic        data_ready;
  logic [63:0] data_addr;
  logic [1:0]  data_size;
  logic [63:0] data_wdata;
  logic [7:0]  data_wstrb;
  logic [63:0] data_rdata;
  logic [1:0]  data_resp;
  logic        rw_valid;
  logic        rw_ready;
  logic        rw_req;
  logic [63:0] rw_addr;
  logic [1:0]  rw_size;
  logic [63:0] rw_wdata;
  logic [7:0]  rw_wstrb;
  logic [63:0] rw_rdata;
  logic [1:0]  rw_resp;
  logic        grant_data;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  ysyx_210247_mem_arbiter #(
    .ADDR_W(64), .DATA_W(64), .MAX_DATA_STREAK(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_addr(inst_addr),
    .inst_size(inst_size), .inst_read(inst_read), .inst_resp(inst_resp),
    .data_valid(data_valid), .data_wen(data_wen), .data_ready(data_ready),
    .data_addr(data_addr), .data_size(data_size), .data_wdata(data_wdata),
    .data_wstrb(data_wstrb), .data_rdata(data_rdata), .data_resp(data_resp),
    .rw_valid(rw_valid), .rw_ready(rw_ready), .rw_req(rw_req), .rw_addr(rw_addr),
    .rw_size(rw_size), .rw_wdata(rw_wdata), .rw_wstrb(rw_wstrb),
    .rw_rdata(rw_rdata), .rw_resp(rw_resp),
    .grant_data(grant_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the falling edge; inputs are driven and outputs sampled here.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Wait (bounded) for the bridge request, return which side owns it, then complete it.
  task automatic run_txn(output logic gd);
    int n;
    n = 0;
    while (!rw_valid && n < 6) begin
      step();
      n++;
    end
    check_eq("txn_rw_valid", {63'd0, rw_valid}, 64'd1);
    gd = grant_data;
    rw_ready = 1'b1;
    #1;
    check_eq("txn_ready_pulse", {62'd0, inst_ready, data_ready}, gd ? 64'd1 : 64'd2);
    step();
    rw_ready = 1'b0;
  endtask

  logic       gd;
  logic [9:0] exp_order;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    inst_valid = 0; inst_addr = 0; inst_size = 2'b10;
    data_valid = 0; data_wen = 0; data_addr = 0; data_size = 2'b11;
    data_wdata = 0; data_wstrb = 0;
    rw_ready = 0; rw_rdata = 0; rw_resp = 0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_rw_valid", {63'd0, rw_valid}, 64'd0);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_grant_data", {63'd0, grant_data}, 64'd0);
    check_eq("rst_readys", {62'd0, inst_ready, data_ready}, 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // rw_ready while idle is ignored
    rw_ready = 1'b1;
    #1;
    check_eq("idle_ready_ignored", {62'd0, inst_ready, data_ready}, 64'd0);
    step();
    rw_ready = 1'b0;
    check_eq("idle_stays", {63'd0, busy}, 64'd0);

    // Fetch only
    inst_valid = 1'b1; inst_addr = 64'h8000_0000;
    step();
    inst_valid = 1'b0;
    check_eq("fetch_rw_valid", {63'd0, rw_valid}, 64'd1);
    check_eq("fetch_rw_req", {63'd0, rw_req}, 64'd0);
    check_eq("fetch_rw_addr", rw_addr, 64'h8000_0000);
    check_eq("fetch_grant_data", {63'd0, grant_data}, 64'd0);
    step();
    step();
    rw_ready = 1'b1; rw_rdata = 64'h13; rw_resp = 2'b00;
    #1;
    check_eq("fetch_inst_ready", {63'd0, inst_ready}, 64'd1);
    check_eq("fetch_inst_read", inst_read, 64'h13);
    check_eq("fetch_data_ready", {63'd0, data_ready}, 64'd0);
    check_eq("fetch_data_rdata", data_rdata, 64'd0);
    step();
    rw_ready = 1'b0; rw_rdata = 0;
    check_eq("fetch_done_rw_valid", {63'd0, rw_valid}, 64'd0);
    check_eq("fetch_pulse_ends", {63'd0, inst_ready}, 64'd0);

    // Simultaneous: data write first, then fetch with an error response
    inst_valid = 1'b1; inst_addr = 64'h8000_0040;
    data_valid = 1'b1; data_wen = 1'b1; data_addr = 64'h8000_1000;
    data_wdata = 64'hDEAD; data_wstrb = 8'hFF;
    step();
    data_valid = 1'b0;
    check_eq("sim_grant_data", {63'd0, grant_data}, 64'd1);
    check_eq("sim_rw_req", {63'd0, rw_req}, 64'd1);
    check_eq("sim_rw_wstrb", {56'd0, rw_wstrb}, 64'hFF);
    check_eq("sim_rw_addr", rw_addr, 64'h8000_1000);
    check_eq("sim_rw_wdata", rw_wdata, 64'hDEAD);
    rw_ready = 1'b1; rw_resp = 2'b00;
    #1;
    check_eq("sim_data_ready", {62'd0, inst_ready, data_ready}, 64'd1);
    step();
    rw_ready = 1'b0;
    check_eq("sim_gap_idle", {63'd0, busy}, 64'd0);
    step();
    inst_valid = 1'b0;
    check_eq("sim_then_inst", {62'd0, busy, grant_data}, 64'd2);
    check_eq("inst_rw_req", {63'd0, rw_req}, 64'd0);
    check_eq("inst_rw_wstrb", {56'd0, rw_wstrb}, 64'd0);
    check_eq("inst_rw_addr", rw_addr, 64'h8000_0040);
    rw_ready = 1'b1; rw_resp = 2'b10; rw_rdata = 64'h55;
    #1;
    check_eq("err_inst_ready", {63'd0, inst_ready}, 64'd1);
    check_eq("err_inst_resp", {62'd0, inst_resp}, 64'd2);
    check_eq("err_data_resp", {62'd0, data_resp}, 64'd0);
    step();
    rw_ready = 1'b0; rw_resp = 2'b00; rw_rdata = 0;
    check_eq("err_back_idle", {63'd0, busy}, 64'd0);

    // Starvation guard: both held high -> D,D,D,D,I repeating (bit i = data grant i)
    exp_order = 10'b01111_01111;
    inst_valid = 1'b1; data_valid = 1'b1; data_wen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      run_txn(gd);
      check_eq($sformatf("starve_grant_%0d", i), {63'd0, gd}, {63'd0, exp_order[i]});
    end
    inst_valid = 1'b0; data_valid = 1'b0;
    step();

    // Mid-transaction requester change is ignored
    data_valid = 1'b1; data_wen = 1'b0; data_addr = 64'h100;
    step();
    data_addr = 64'h200; data_valid = 1'b0;
    check_eq("mid_rw_addr_grant", rw_addr, 64'h100);
    step();
    check_eq("mid_rw_addr_held", rw_addr, 64'h100);
    check_eq("mid_still_valid", {63'd0, rw_valid}, 64'd1);
    rw_ready = 1'b1; rw_rdata = 64'hABCD;
    #1;
    check_eq("mid_data_ready", {63'd0, data_ready}, 64'd1);
    check_eq("mid_data_rdata", data_rdata, 64'hABCD);
    step();
    rw_ready = 1'b0; rw_rdata = 0;

    // Async reset during a data transaction
    data_valid = 1'b1; inst_valid = 1'b1;
    step();
    data_valid = 1'b0; inst_valid = 1'b0;
    check_eq("ar_in_data", {63'd0, grant_data}, 64'd1);
    #2 rst_n = 1'b0;
    rw_ready = 1'b1;
    #1;
    check_eq("ar_rw_valid", {63'd0, rw_valid}, 64'd0);
    check_eq("ar_busy", {63'd0, busy}, 64'd0);
    check_eq("ar_no_pulse", {62'd0, inst_ready, data_ready}, 64'd0);
    step();
    rw_ready = 1'b0;
    rst_n = 1'b1;
    inst_valid = 1'b1; inst_addr = 64'h8000_0080;
    step();
    inst_valid = 1'b0;
    check_eq("ar_inst_grant", {62'd0, busy, grant_data}, 64'd2);
    check_eq("ar_inst_addr", rw_addr, 64'h8000_0080);
    rw_ready = 1'b1;
    #1;
    check_eq("ar_inst_ready", {63'd0, inst_ready}, 64'd1);
    step();
    rw_ready = 1'b0;

    // Streak restarted at 0 after reset: four data grants before fetch wins again
    exp_order = 10'b00000_01111;
    inst_valid = 1'b1; data_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run_txn(gd);
      check_eq($sformatf("post_rst_grant_%0d", i), {63'd0, gd}, {63'd0, exp_order[i]});
    end
    inst_valid = 1'b0; data_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_210247_mem_arbiter.md
Name: ysyx_210247_mem_arbiter

Overview:
- Shares the single memory request channel into the AXI master bridge between the instruction-fetch port and the load/store data port.
- Grants one requester at a time and latches its request for the whole transaction.
- Returns the bridge's one-cycle ready/rdata/resp pulse to the granted port only.
- Data has priority; a streak counter stops fetch starvation.

Parameters:
- ADDR_W, 64, request address width
- DATA_W, 64, read/write data width
- MAX_DATA_STREAK, 4, consecutive data grants allowed while fetch waits (range 1..15)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- inst_valid  in  1  fetch request; may be held high back-to-back
- inst_ready  out  1  one-cycle completion pulse to fetch
- inst_addr  in  ADDR_W  fetch address
- inst_size  in  2  fetch size code
- inst_read  out  DATA_W  fetch read data, valid with inst_ready
- inst_resp  out  2  fetch response, valid with inst_ready
- data_valid  in  1  load/store request
- data_wen  in  1  1 = write, 0 = read
- data_ready  out  1  one-cycle completion pulse to data port
- data_addr  in  ADDR_W  data address
- data_size  in  2  data size code
- data_wdata  in  DATA_W  write data
- data_wstrb  in  DATA_W/8  write byte strobes
- data_rdata  out  DATA_W  read data, valid with data_ready
- data_resp  out  2  data response, valid with data_ready
- rw_valid  out  1  request to bridge
- rw_ready  in  1  one-cycle completion from bridge
- rw_req  out  1  1 = write
- rw_addr  out  ADDR_W  latched address
- rw_size  out  2  latched size
- rw_wdata  out  DATA_W  latched write data
- rw_wstrb  out  DATA_W/8  latched strobes; all-zero for fetch
- rw_rdata  in  DATA_W  bridge read data
- rw_resp  in  2  bridge response
- grant_data  out  1  1 while the DATA state owns the bus
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, INST, DATA.
- Reset (asynchronous, rst_n=0): state IDLE, streak 0, all latched request registers 0. All outputs 0: rw_valid, inst_ready, data_ready, busy, grant_data.
- IDLE, arbitration each cycle:
  - data_valid only -> DATA.
  - inst_valid only -> INST.
  - Both valid and streak < MAX_DATA_STREAK -> DATA.
  - Both valid and streak == MAX_DATA_STREAK -> INST.
  - Neither valid -> stay IDLE.
- On entering INST/DATA, latch addr, size, wen, wdata and wstrb from the winner. Latched values are held until completion. Requester changes or dropped valid mid-transaction are ignored.
- INST/DATA:
  - rw_valid = 1; rw_* driven from the latched registers.
  - Fetch grants force rw_req = 0 and rw_wstrb = 0.
- Completion: rw_ready=1 in INST/DATA.
  - Same cycle, combinationally: the granted port's ready = 1; its rdata/resp = rw_rdata/rw_resp.
  - The other port's ready stays 0; its rdata/resp are 0.
  - Next state is IDLE, so rw_valid drops the following cycle.
- rw_ready while IDLE: ignored; no ready pulse to either port.
- Latency: request seen in IDLE at cycle N -> rw_valid from N+1. There is a minimum 1 idle cycle between consecutive transactions.
- Streak update, on each grant:
  - Data grant with inst_valid high -> streak+1, saturating at MAX_DATA_STREAK.
  - Inst grant, or data grant with inst_valid low -> streak = 0.
- Response codes pass through unmodified. A non-OKAY resp still completes the transaction normally.
- Reset asserted mid-transaction: immediate return to IDLE. No ready pulse is issued and the transaction is dropped. The bridge is reset by the same rst_n.
- busy = (state != IDLE); grant_data = (state == DATA).

Decomposition:
- Shared defines: state encodings (IDLE=2'd0, INST=2'd1, DATA=2'd2), response codes (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11), and the existing SIZE_B/H/W/D codes and REG_BUS width.
- Single module; no sub-module is warranted. The streak counter and state register stay inline.

Test Plan:
- Fetch only: inst_valid=1, inst_addr=0x80000000, bridge returns rw_ready with rw_rdata=0x00000013 after 3 cycles -> rw_valid from cycle 1, rw_req=0. inst_ready pulses 1 cycle with inst_read=0x13. data_ready stays 0.
- Simultaneous: inst_valid=1 and data_valid=1 (write 0x80001000, wdata=0xDEAD, wstrb=0xFF) -> DATA granted first: rw_req=1, rw_wstrb=0xFF. After data_ready, the next grant is INST (data_valid low by then).
- Starvation: inst_valid and data_valid both held high, MAX_DATA_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I.
- Mid-transaction change: after grant, data_addr changes from 0x100 to 0x200 and data_valid drops -> rw_addr stays 0x100; data_ready still pulses on rw_ready.
- Error: bridge returns rw_resp=2'b10 on a fetch -> inst_resp=2'b10 with the inst_ready pulse; state returns to IDLE.
- Async reset: rst_n low during DATA, between clock edges -> rw_valid=0 and busy=0 immediately, no ready pulse. After release with inst_valid=1 -> INST granted, streak=0.
